// File: rtl/vector_alu_sequencer.sv
// Drives one shared scalar ALU across a packed operand vector, one lane per clock,
// and presents the collected result vector and per-lane flag masks with a done pulse.
module vector_alu_sequencer #(
  parameter int dataSize = 8,
  parameter int lanes    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic                        scalar_b,
  input  logic [lanes*dataSize-1:0]   vec_a,
  input  logic [lanes*dataSize-1:0]   vec_b,
  output logic [2:0]                  alu_op,
  output logic [dataSize-1:0]         alu_a,
  output logic [dataSize-1:0]         alu_b,
  input  logic [dataSize-1:0]         alu_result,
  input  logic                        alu_neg,
  input  logic                        alu_zero,
  output logic                        busy,
  output logic                        done,
  output logic [lanes*dataSize-1:0]   vec_result,
  output logic [lanes-1:0]            neg_mask,
  output logic [lanes-1:0]            zero_mask
);

  localparam int              VW   = lanes * dataSize;
  localparam int              IW   = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [IW-1:0]   LAST = IW'(lanes - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [VW-1:0]     a_q, a_d;
  logic [VW-1:0]     b_q, b_d;
  logic [VW-1:0]     work_q, work_d;
  logic [lanes-1:0]  wneg_q, wneg_d;
  logic [lanes-1:0]  wzero_q, wzero_d;
  logic [VW-1:0]     vec_result_q, vec_result_d;
  logic [lanes-1:0]  neg_mask_q, neg_mask_d;
  logic [lanes-1:0]  zero_mask_q, zero_mask_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    work_d       = work_q;
    wneg_d       = wneg_q;
    wzero_d      = wzero_q;
    vec_result_d = vec_result_q;
    neg_mask_d   = neg_mask_q;
    zero_mask_d  = zero_mask_q;
    alu_op       = 3'b000;
    alu_a        = '0;
    alu_b        = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          op_d    = op;
          a_d     = vec_a;
          b_d     = scalar_b ? {lanes{vec_b[dataSize-1:0]}} : vec_b;
        end
      end
      S_RUN: begin
        alu_op = op_q;
        alu_a  = a_q[idx_q*dataSize +: dataSize];
        alu_b  = b_q[idx_q*dataSize +: dataSize];
        work_d[idx_q*dataSize +: dataSize] = alu_result;
        wneg_d[idx_q]  = alu_neg;
        wzero_d[idx_q] = alu_zero;
        if (idx_q == LAST) begin
          // Publish including the lane captured on this same edge.
          state_d      = S_DONE;
          vec_result_d = work_d;
          neg_mask_d   = wneg_d;
          zero_mask_d  = wzero_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the working vector and operand latches are reset too, so a reset mid-RUN leaves no stale lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      wneg_q       <= '0;
      wzero_q      <= '0;
      vec_result_q <= '0;
      neg_mask_q   <= '0;
      zero_mask_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      work_q       <= work_d;
      wneg_q       <= wneg_d;
      wzero_q      <= wzero_d;
      vec_result_q <= vec_result_d;
      neg_mask_q   <= neg_mask_d;
      zero_mask_q  <= zero_mask_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign vec_result = vec_result_q;
  assign neg_mask   = neg_mask_q;
  assign zero_mask  = zero_mask_q;

endmodule
